// File: rtl/exec_pkg.sv
// Shared micro-op encodings, branch codes, the Decode/Execute bundle layout
// and the issue controller state type.
package exec_pkg;

  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_AND = 5'd3;
  localparam logic [4:0] UOP_EOR = 5'd4;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_MOV = 5'd8;
  localparam logic [4:0] UOP_STR = 5'd9;
  localparam logic [4:0] UOP_LDR = 5'd10;

  localparam logic [3:0] BR_NONE = 4'b1111;
  localparam logic [3:0] BR_AL   = 4'b1110;

  localparam int UOP_W = 54;

  typedef struct packed {
    logic        num_to_rhs;
    logic [31:0] num;
    logic [3:0]  sel_p0;
    logic [3:0]  sel_p1;
    logic [3:0]  sel_in;
    logic [4:0]  uop;
    logic [3:0]  branch_cond;
  } uop_bundle_t;

  localparam uop_bundle_t UOP_BUBBLE = '{
    num_to_rhs:  1'b0,
    num:         32'd0,
    sel_p0:      4'd0,
    sel_p1:      4'd0,
    sel_in:      4'd0,
    uop:         UOP_NOP,
    branch_cond: BR_NONE
  };

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } issue_state_t;

endpackage

// File: rtl/exec_uop_fifo.sv
// Small synchronous FIFO of decoded micro-op bundles; head is visible
// combinationally, clear discards all entries at the edge.
module exec_uop_fifo
  import exec_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [UOP_W-1:0] din,
  output logic [UOP_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [UOP_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear && push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issue controller between Decode and Execute: buffers micro-ops, stalls on
// load-use hazards, drains the wrong path after a taken branch.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal issue, one op per cycle when no hazard
//   ST_STALL | head depends on an in-flight LDR; bubble until ld_cnt hits 0
//   ST_FLUSH | wrong-path drain after redirect; no issue, no push
module exec_issue_ctrl
  import exec_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic        dec_num_to_rhs,
  input  logic [31:0] dec_num,
  input  logic [3:0]  dec_sel_p0,
  input  logic [3:0]  dec_sel_p1,
  input  logic [3:0]  dec_sel_in,
  input  logic [4:0]  dec_uop,
  input  logic [3:0]  dec_branch_cond,
  output logic        ex_num_to_rhs,
  output logic [31:0] ex_num,
  output logic [3:0]  ex_sel_p0,
  output logic [3:0]  ex_sel_p1,
  output logic [3:0]  ex_sel_in,
  output logic [4:0]  ex_uop,
  output logic [3:0]  ex_branch_cond,
  input  logic        ex_global_disable,
  input  logic [31:0] ex_delta_instruction,
  output logic        redirect_valid,
  output logic [31:0] redirect_delta,
  output logic        busy
);

  localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam int LW = (LOAD_LATENCY < 1) ? 1 : $clog2(LOAD_LATENCY + 1);

  issue_state_t     state, state_nxt;
  logic [FW-1:0]    flush_cnt, flush_cnt_nxt;
  logic [LW-1:0]    ld_cnt, ld_cnt_nxt;
  logic [3:0]       ld_dest, ld_dest_nxt;
  uop_bundle_t      ex_q, ex_nxt;
  uop_bundle_t      head, dec_bundle;
  logic [UOP_W-1:0] head_bits;
  logic             full, empty, push, pop, hazard;

  assign dec_bundle = '{
    num_to_rhs:  dec_num_to_rhs,
    num:         dec_num,
    sel_p0:      dec_sel_p0,
    sel_p1:      dec_sel_p1,
    sel_in:      dec_sel_in,
    uop:         dec_uop,
    branch_cond: dec_branch_cond
  };

  assign dec_ready = rst_n && !full && (state != ST_FLUSH);
  // A redirect in the same cycle wins: the offered op is wrong-path.
  assign push      = dec_valid && dec_ready && !ex_global_disable;
  assign head      = head_bits;
  assign busy      = !empty || (state != ST_RUN);

  // Conservative: both read ports compare even when the immediate feeds RHS.
  assign hazard = !empty && (ld_cnt != '0) && (head.uop != UOP_NOP) &&
                  ((head.sel_p0 == ld_dest) || (head.sel_p1 == ld_dest));

  exec_uop_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (ex_global_disable),
    .din   (dec_bundle),
    .head  (head_bits),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    ld_cnt_nxt    = (ld_cnt != '0) ? ld_cnt - LW'(1) : ld_cnt;
    ld_dest_nxt   = ld_dest;
    ex_nxt        = UOP_BUBBLE;
    pop           = 1'b0;
    if (ex_global_disable) begin
      state_nxt     = ST_FLUSH;
      flush_cnt_nxt = FW'(FLUSH_CYCLES);
    end else begin
      case (state)
        ST_RUN, ST_STALL: begin
          if (hazard) begin
            state_nxt = ST_STALL;
          end else begin
            state_nxt = ST_RUN;
            if (!empty) begin
              pop    = 1'b1;
              ex_nxt = head;
              if (head.uop == UOP_LDR) begin
                ld_cnt_nxt  = LW'(LOAD_LATENCY);
                ld_dest_nxt = head.sel_in;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt <= FW'(1)) begin
            state_nxt     = ST_RUN;
            flush_cnt_nxt = '0;
          end else begin
            flush_cnt_nxt = flush_cnt - FW'(1);
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      flush_cnt      <= '0;
      ld_cnt         <= '0;
      ld_dest        <= '0;
      ex_q           <= UOP_BUBBLE;
      redirect_valid <= 1'b0;
      redirect_delta <= '0;
    end else begin
      state          <= state_nxt;
      flush_cnt      <= flush_cnt_nxt;
      ld_cnt         <= ld_cnt_nxt;
      ld_dest        <= ld_dest_nxt;
      ex_q           <= ex_nxt;
      redirect_valid <= ex_global_disable;
      if (ex_global_disable) redirect_delta <= ex_delta_instruction;
    end
  end

  assign ex_num_to_rhs  = ex_q.num_to_rhs;
  assign ex_num         = ex_q.num;
  assign ex_sel_p0      = ex_q.sel_p0;
  assign ex_sel_p1      = ex_q.sel_p1;
  assign ex_sel_in      = ex_q.sel_in;
  assign ex_uop         = ex_q.uop;
  assign ex_branch_cond = ex_q.branch_cond;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Bench for exec_issue_ctrl: directed scenarios plus random traffic, all
// compared against a queue-based reference model of the issue rules.
module tb_exec_issue_ctrl;

  localparam int DEPTH = 2;
  localparam int LOAD_LATENCY = 1;
  localparam int FLUSH_CYCLES = 2;

  typedef struct packed {
    logic        nrhs;
    logic [31:0] num;
    logic [3:0]  p0;
    logic [3:0]  p1;
    logic [3:0]  pin;
    logic [4:0]  uop;
    logic [3:0]  bc;
  } op_t;

  localparam op_t BUBBLE = '{nrhs: 1'b0, num: 32'd0, p0: 4'd0, p1: 4'd0,
                             pin: 4'd0, uop: 5'd0, bc: 4'b1111};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0;
  op_t         din = BUBBLE;
  logic        gd = 1'b0;
  logic [31:0] delta = 32'd0;

  logic        dec_ready, ex_num_to_rhs, redirect_valid, busy;
  logic [31:0] ex_num, redirect_delta;
  logic [3:0]  ex_sel_p0, ex_sel_p1, ex_sel_in, ex_branch_cond;
  logic [4:0]  ex_uop;

  always #5 clk = ~clk;

  exec_issue_ctrl #(.DEPTH(DEPTH), .LOAD_LATENCY(LOAD_LATENCY), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .dec_valid            (dec_valid),
    .dec_ready            (dec_ready),
    .dec_num_to_rhs       (din.nrhs),
    .dec_num              (din.num),
    .dec_sel_p0           (din.p0),
    .dec_sel_p1           (din.p1),
    .dec_sel_in           (din.pin),
    .dec_uop              (din.uop),
    .dec_branch_cond      (din.bc),
    .ex_num_to_rhs        (ex_num_to_rhs),
    .ex_num               (ex_num),
    .ex_sel_p0            (ex_sel_p0),
    .ex_sel_p1            (ex_sel_p1),
    .ex_sel_in            (ex_sel_in),
    .ex_uop               (ex_uop),
    .ex_branch_cond       (ex_branch_cond),
    .ex_global_disable    (gd),
    .ex_delta_instruction (delta),
    .redirect_valid       (redirect_valid),
    .redirect_delta       (redirect_delta),
    .busy                 (busy)
  );

  // Reference model: pending ops in a queue, cycles left on the load and
  // drain windows, and whether the head is currently held back.
  op_t         q[$];
  op_t         m_ex = BUBBLE;
  logic        m_rv = 1'b0;
  logic [31:0] m_rd = 32'd0;
  int          flush_left = 0;
  int          ld_left = 0;
  logic [3:0]  ld_reg = 4'd0;
  bit          stalled = 1'b0;

  int total = 0;
  int bad = 0;

  function automatic op_t mk(input logic [4:0] uop, input logic [3:0] p0, input logic [3:0] p1,
                             input logic [3:0] pin, input logic nrhs, input logic [31:0] num,
                             input logic [3:0] bc);
    op_t o;
    o = '{nrhs: nrhs, num: num, p0: p0, p1: p1, pin: pin, uop: uop, bc: bc};
    return o;
  endfunction

  function automatic op_t ex_obs();
    op_t o;
    o = '{nrhs: ex_num_to_rhs, num: ex_num, p0: ex_sel_p0, p1: ex_sel_p1,
          pin: ex_sel_in, uop: ex_uop, bc: ex_branch_cond};
    return o;
  endfunction

  function automatic logic [88:0] obs();
    return {ex_obs(), redirect_valid, redirect_delta, dec_ready, busy};
  endfunction

  function automatic logic [88:0] exp_obs();
    logic rdy, bsy;
    rdy = rst_n && (q.size() < DEPTH) && (flush_left == 0);
    bsy = (q.size() != 0) || (flush_left != 0) || stalled;
    return {m_ex, m_rv, m_rd, rdy, bsy};
  endfunction

  // One clock: snapshot the driven inputs, take the edge, advance the model.
  task automatic step();
    logic        v, g, r, rdy;
    op_t         d;
    logic [31:0] dl;
    int          ld_next;
    op_t         h;
    v = dec_valid; g = gd; r = rst_n; d = din; dl = delta;
    rdy = r && (q.size() < DEPTH) && (flush_left == 0);
    @(posedge clk);
    #1;
    if (!r) begin
      q.delete();
      m_ex = BUBBLE; m_rv = 1'b0; m_rd = 32'd0;
      flush_left = 0; ld_left = 0; ld_reg = 4'd0; stalled = 1'b0;
    end else begin
      ld_next = (ld_left > 0) ? ld_left - 1 : 0;
      m_ex = BUBBLE;
      m_rv = g;
      if (g) begin
        q.delete();
        m_rd = dl;
        flush_left = FLUSH_CYCLES;
        stalled = 1'b0;
      end else begin
        if (flush_left > 0) begin
          flush_left--;
        end else if (q.size() > 0 && ld_left > 0 && q[0].uop != 5'd0 &&
                     (q[0].p0 == ld_reg || q[0].p1 == ld_reg)) begin
          stalled = 1'b1;
        end else begin
          stalled = 1'b0;
          if (q.size() > 0) begin
            h = q.pop_front();
            m_ex = h;
            if (h.uop == 5'd10) begin
              ld_next = LOAD_LATENCY;
              ld_reg = h.pin;
            end
          end
        end
        if (v && rdy) q.push_back(d);
      end
      ld_left = ld_next;
    end
  endtask

  task automatic idle(input int n);
    dec_valid = 1'b0; gd = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dec_valid = 1'b0; gd = 1'b0; din = BUBBLE;
    repeat (2) begin
      step();
      total++;
      if (obs() !== exp_obs()) begin bad++; $display("FAIL reset_model got=%h want=%h", obs(), exp_obs()); end
    end
    total++;
    if (dec_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", dec_ready); end
    total++;
    if (ex_obs() !== BUBBLE || redirect_valid !== 1'b0 || redirect_delta !== 32'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_outputs ex=%h rv=%b rd=%h busy=%b", ex_obs(), redirect_valid, redirect_delta, busy);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (dec_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", dec_ready); end
  endtask

  task automatic test_back_to_back();
    op_t ops[3];
    ops[0] = mk(5'd8, 4'd0, 4'd0, 4'd1, 1'b1, 32'hCAFE, 4'b1111);
    ops[1] = mk(5'd8, 4'd0, 4'd0, 4'd2, 1'b1, 32'hDEAD, 4'b1111);
    ops[2] = mk(5'd1, 4'd1, 4'd2, 4'd4, 1'b0, 32'd0, 4'b1111);
    for (int k = 1; k <= 6; k++) begin
      dec_valid = (k <= 3);
      din = (k <= 3) ? ops[k-1] : BUBBLE;
      step();
      total++;
      if (obs() !== exp_obs()) begin bad++; $display("FAIL b2b_model k=%0d got=%h want=%h", k, obs(), exp_obs()); end
      if (k >= 2 && k <= 4) begin
        total++;
        if (ex_obs() !== ops[k-2]) begin bad++; $display("FAIL b2b_order k=%0d got=%h want=%h", k, ex_obs(), ops[k-2]); end
      end
    end
    idle(2);
  endtask

  // Pushes a producer then a consumer back to back and returns how many
  // bubbles separated them on ex_*, plus busy during the first gap cycle.
  task automatic run_pair(input op_t a, input op_t b, input string tag,
                          output int gap, output logic gap_busy);
    logic [4:0] hu[8];
    logic       hb[8];
    int         ia, ib;
    ia = -1; ib = -1;
    for (int k = 0; k < 8; k++) begin
      dec_valid = (k < 2);
      din = (k == 0) ? a : ((k == 1) ? b : BUBBLE);
      step();
      total++;
      if (obs() !== exp_obs()) begin bad++; $display("FAIL %s_model k=%0d got=%h want=%h", tag, k, obs(), exp_obs()); end
      hu[k] = ex_uop; hb[k] = busy;
      if (ex_uop == a.uop && ex_num == a.num && ia < 0) ia = k;
      if (ex_uop == b.uop && ex_num == b.num && ib < 0) ib = k;
    end
    gap = (ia >= 0 && ib > ia) ? ib - ia - 1 : -1;
    gap_busy = (ia >= 0 && ia < 7) ? hb[ia+1] : 1'bx;
    if (hu[0] === 5'bx) gap = -2;
    idle(2);
  endtask

  task automatic test_load_use();
    int gap; logic gb;
    run_pair(mk(5'd10, 4'd6, 4'd0, 4'd8, 1'b1, 32'd28, 4'b1111),
             mk(5'd6, 4'd8, 4'd0, 4'd9, 1'b1, 32'd8, 4'b1111), "load_use", gap, gb);
    total++;
    if (gap !== LOAD_LATENCY) begin bad++; $display("FAIL load_use_bubbles got=%0d want=%0d", gap, LOAD_LATENCY); end
    total++;
    if (gb !== 1'b1) begin bad++; $display("FAIL load_use_busy got=%b want=1", gb); end
  endtask

  task automatic test_load_indep();
    int gap; logic gb;
    run_pair(mk(5'd10, 4'd6, 4'd0, 4'd8, 1'b1, 32'd28, 4'b1111),
             mk(5'd4, 4'd1, 4'd3, 4'd1, 1'b0, 32'd77, 4'b1111), "load_indep", gap, gb);
    total++;
    if (gap !== 0) begin bad++; $display("FAIL load_indep_bubbles got=%0d want=0", gap); end
  endtask

  task automatic test_redirect();
    op_t br, oa, ob;
    br = mk(5'd0, 4'd0, 4'd0, 4'd0, 1'b1, 32'd10, 4'b1110);
    oa = mk(5'd8, 4'd0, 4'd0, 4'd3, 1'b1, 32'h111, 4'b1111);
    ob = mk(5'd8, 4'd0, 4'd0, 4'd5, 1'b1, 32'h222, 4'b1111);
    dec_valid = 1'b1; din = br; step();
    din = oa; step();
    total++;
    if (ex_obs() !== br) begin bad++; $display("FAIL redirect_branch_issue got=%h want=%h", ex_obs(), br); end
    din = ob; gd = 1'b1; delta = 32'd10; step();
    gd = 1'b0; delta = 32'd0;
    total++;
    if (redirect_valid !== 1'b1 || redirect_delta !== 32'd10 || ex_obs() !== BUBBLE) begin
      bad++; $display("FAIL redirect_pulse rv=%b rd=%0d ex=%h want rv=1 rd=10 bubble", redirect_valid, redirect_delta, ex_obs());
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (obs() !== exp_obs()) begin bad++; $display("FAIL redirect_model k=%0d got=%h want=%h", k, obs(), exp_obs()); end
      total++;
      if (dec_ready !== (k >= 2)) begin bad++; $display("FAIL redirect_ready k=%0d got=%b want=%b", k, dec_ready, (k >= 2)); end
      if (k >= 1) begin
        total++;
        if (redirect_valid !== 1'b0 || ex_obs() !== BUBBLE) begin
          bad++; $display("FAIL redirect_after k=%0d rv=%b ex=%h want rv=0 bubble", k, redirect_valid, ex_obs());
        end
      end
      dec_valid = 1'b0;
      step();
    end
    idle(1);
  endtask

  task automatic test_fifo_full();
    op_t  ops[5];
    int   idx, n_got;
    logic [31:0] got[8];
    bit   saw_full, acc;
    ops[0] = mk(5'd10, 4'd6, 4'd0, 4'd8, 1'b1, 32'd100, 4'b1111);
    ops[1] = mk(5'd1, 4'd8, 4'd2, 4'd4, 1'b0, 32'd101, 4'b1111);
    ops[2] = mk(5'd8, 4'd0, 4'd0, 4'd5, 1'b1, 32'd102, 4'b1111);
    ops[3] = mk(5'd8, 4'd0, 4'd0, 4'd7, 1'b1, 32'd103, 4'b1111);
    ops[4] = mk(5'd4, 4'd1, 4'd3, 4'd1, 1'b0, 32'd104, 4'b1111);
    idx = 0; n_got = 0; saw_full = 1'b0;
    for (int k = 0; k < 30; k++) begin
      dec_valid = (idx < 5);
      din = (idx < 5) ? ops[idx] : BUBBLE;
      acc = dec_valid && dec_ready;
      step();
      if (acc) idx++;
      total++;
      if (obs() !== exp_obs()) begin bad++; $display("FAIL full_model k=%0d got=%h want=%h", k, obs(), exp_obs()); end
      if (ex_uop != 5'd0 && n_got < 8) begin got[n_got] = ex_num; n_got++; end
      if (dec_ready === 1'b0 && idx < 5) saw_full = 1'b1;
    end
    total++;
    if (!saw_full) begin bad++; $display("FAIL full_ready_low got=never want=seen"); end
    total++;
    if (n_got != 5) begin bad++; $display("FAIL full_count got=%0d want=5", n_got); end
    for (int i = 0; i < 5 && i < n_got; i++) begin
      total++;
      if (got[i] !== ops[i].num) begin bad++; $display("FAIL full_order i=%0d got=%0d want=%0d", i, got[i], ops[i].num); end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_flush();
    dec_valid = 1'b1; din = mk(5'd8, 4'd0, 4'd0, 4'd2, 1'b1, 32'h55, 4'b1111); step();
    gd = 1'b1; delta = 32'h1234; step();
    gd = 1'b0; dec_valid = 1'b0;
    rst_n = 1'b0; step();
    total++;
    if (redirect_valid !== 1'b0 || ex_obs() !== BUBBLE || busy !== 1'b0 || redirect_delta !== 32'd0) begin
      bad++; $display("FAIL rst_flush rv=%b ex=%h busy=%b rd=%h want 0/bubble/0/0", redirect_valid, ex_obs(), busy, redirect_delta);
    end
    total++;
    if (obs() !== exp_obs()) begin bad++; $display("FAIL rst_flush_model got=%h want=%h", obs(), exp_obs()); end
    rst_n = 1'b1; step();
    total++;
    if (dec_ready !== 1'b1) begin bad++; $display("FAIL rst_flush_ready got=%b want=1", dec_ready); end
  endtask

  function automatic op_t rand_op();
    logic [4:0] u;
    case ($urandom_range(0, 9))
      0: u = 5'd0;  1: u = 5'd1;  2: u = 5'd3;  3: u = 5'd4;  4: u = 5'd5;
      5: u = 5'd6;  6: u = 5'd8;  7: u = 5'd9;  default: u = 5'd10;
    endcase
    return mk(u, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111);
  endfunction

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      dec_valid = ($urandom_range(0, 9) < 7);
      din = rand_op();
      gd = ($urandom_range(0, 19) == 0);
      delta = $urandom;
      rst_n = ($urandom_range(0, 79) != 0);
      step();
      total++;
      if (obs() !== exp_obs()) begin bad++; $display("FAIL random_model k=%0d got=%h want=%h", k, obs(), exp_obs()); end
    end
    rst_n = 1'b1; gd = 1'b0; dec_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_load_indep();
    test_redirect();
    test_fifo_full();
    test_reset_mid_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
